// File: rtl/multi_dds_if.sv
// ============================================================================
// Module      : multi_dds_if
// Description : Wishbone register-bus bundle for the multi_dds synthesiser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multi_dds_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic [ADDR_WIDTH-1:0] wb_addr_i;
    logic                  wb_we_i;
    logic                  wb_stb_i;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic                  wb_ack_o;

    modport master (
        output wb_dat_i, wb_addr_i, wb_we_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_dat_i, wb_addr_i, wb_we_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

`default_nettype wire

// File: rtl/multi_dds.sv
// ============================================================================
// Module      : multi_dds
// Description : NUM_CH-channel DDS (sine/saw/tri/rand) with Wishbone registers.
//               Optional output clamp enabled by defining MULTI_DDS_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_dds #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int WAVE_WIDTH     = 16,
    parameter int NUM_CH         = 4,
    parameter int PHASE_WIDTH    = 24,
    parameter int LUT_ADDR_WIDTH = 8
) (
    input  wire logic                         wb_clk_i,
    input  wire logic                         wb_rst_i,
    multi_dds_if.slave                        wb,
    output logic [NUM_CH*WAVE_WIDTH-1:0]      wave_o
);

    localparam int  c_W        = WAVE_WIDTH;
    localparam int  c_PW       = PHASE_WIDTH;
    localparam int  c_L        = LUT_ADDR_WIDTH;
    localparam int  c_LUT_SIZE = 2**LUT_ADDR_WIDTH;
    localparam int  c_AMP      = 2**(WAVE_WIDTH-1) - 1;
    localparam real c_PI       = 3.14159265358979;
    localparam logic [ADDR_WIDTH-1:0] c_CH_BASE = ADDR_WIDTH'(16);
    localparam logic [ADDR_WIDTH-1:0] c_CH_SPAN = ADDR_WIDTH'(4*NUM_CH);
    localparam logic [c_W-1:0]        c_HALF    = {1'b1, {(c_W-1){1'b0}}};
    localparam logic [31:0]           c_TAPS    = 32'h8020_0003;
    localparam logic [1:0] c_SRC_SINE = 2'd0;
    localparam logic [1:0] c_SRC_SAW  = 2'd1;
    localparam logic [1:0] c_SRC_TRI  = 2'd2;

    function automatic int sine_val(input int k);
        real x;
        x = real'(c_AMP) * $sin(2.0 * c_PI * real'(k) / real'(c_LUT_SIZE));
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    logic [c_W-1:0] w_sine_rom [c_LUT_SIZE];

    for (genvar k = 0; k < c_LUT_SIZE; k++) begin : g_sine
        assign w_sine_rom[k] = c_W'(sine_val(k));
    end

    logic                  ack_q;
    logic                  sync_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [ADDR_WIDTH-1:0] w_ch_off;
    logic                  w_ch_hit;
    logic                  w_xfer;
    logic [3:0]            w_ch_idx;
    logic [1:0]            w_reg_off;
    logic [DATA_WIDTH-1:0] w_ch_rd [NUM_CH];
    logic                  w_unused_dat;

    // Offset wraps for addresses below the channel base, so one compare covers both bounds.
    assign w_xfer    = wb.wb_stb_i & ~ack_q;
    assign w_ch_off  = wb.wb_addr_i - c_CH_BASE;
    assign w_ch_hit  = (w_ch_off < c_CH_SPAN);
    assign w_ch_idx  = w_ch_off[5:2];
    assign w_reg_off = w_ch_off[1:0];
    assign w_unused_dat = ^wb.wb_dat_i;

    always_comb begin
        w_rd_data = '0;
        if (wb.wb_addr_i == ADDR_WIDTH'(0)) begin
            w_rd_data = DATA_WIDTH'(1);
        end else if (wb.wb_addr_i == ADDR_WIDTH'(1)) begin
            w_rd_data = DATA_WIDTH'(NUM_CH);
        end else if (w_ch_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_ch_idx == 4'(c)) w_rd_data = w_ch_rd[c];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            sync_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            ack_q  <= w_xfer;
            sync_q <= w_xfer & wb.wb_we_i & (wb.wb_addr_i == ADDR_WIDTH'(2)) & wb.wb_dat_i[0];
            if (w_xfer) dat_q <= wb.wb_we_i ? '0 : w_rd_data;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [5:0]      ctrl_q;
        logic [c_PW-1:0] tuning_q, phase_off_q, acc_q, w_phase;
        logic [c_W-1:0]  amp_off_q, raw_q, wave_q, w_raw, w_tri, w_wave;
        logic [31:0]     lfsr_q, w_lfsr_nxt;
        logic [c_W+4:0]  w_y;
        logic [DATA_WIDTH-1:0] w_rd;
        logic            w_wr;

        assign w_wr       = w_xfer & wb.wb_we_i & w_ch_hit & (w_ch_idx == 4'(c));
        assign w_phase    = acc_q + phase_off_q;
        assign w_lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? c_TAPS : 32'h0);

        always_comb begin
            w_tri = w_phase[c_PW-1] ? ~w_phase[c_PW-2 -: c_W] : w_phase[c_PW-2 -: c_W];
            case (ctrl_q[2:1])
                c_SRC_SINE: w_raw = w_sine_rom[w_phase[c_PW-1 -: c_L]];
                c_SRC_SAW:  w_raw = w_phase[c_PW-1 -: c_W] - c_HALF;
                c_SRC_TRI:  w_raw = w_tri - c_HALF;
                default:    w_raw = lfsr_q[c_W-1:0];
            endcase
        end

        // Sign-extend into W+5 bits so gain and offset cannot overflow before the clamp.
        assign w_y = ({{5{raw_q[c_W-1]}}, raw_q} << ctrl_q[5:4]) + {5'b0, amp_off_q};

`ifdef MULTI_DDS_SAT_EN
        always_comb begin
            if (w_y[c_W+4])          w_wave = '0;
            else if (|w_y[c_W+3:c_W]) w_wave = '1;
            else                      w_wave = w_y[c_W-1:0];
        end
`else
        logic w_unused_y;
        assign w_wave     = w_y[c_W-1:0];
        assign w_unused_y = ^w_y[c_W+4:c_W];
`endif

        always_comb begin
            w_rd = '0;
            case (w_reg_off)
                2'd0:    w_rd = DATA_WIDTH'(ctrl_q);
                2'd1:    w_rd = DATA_WIDTH'(tuning_q);
                2'd2:    w_rd = DATA_WIDTH'(phase_off_q);
                default: w_rd = DATA_WIDTH'(amp_off_q);
            endcase
        end

        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                ctrl_q      <= '0;
                tuning_q    <= c_PW'(1);
                phase_off_q <= '0;
                amp_off_q   <= c_HALF;
                acc_q       <= '0;
                lfsr_q      <= 32'(c + 1);
                raw_q       <= '0;
                wave_q      <= '0;
            end else begin
                if (w_wr) begin
                    case (w_reg_off)
                        2'd0:    ctrl_q      <= wb.wb_dat_i[5:0] & 6'b11_0111;
                        2'd1:    tuning_q    <= wb.wb_dat_i[c_PW-1:0];
                        2'd2:    phase_off_q <= wb.wb_dat_i[c_PW-1:0];
                        default: amp_off_q   <= wb.wb_dat_i[c_W-1:0];
                    endcase
                end
                if (sync_q)         acc_q <= '0;
                else if (ctrl_q[0]) acc_q <= acc_q + tuning_q;
                if (ctrl_q[0]) lfsr_q <= w_lfsr_nxt;
                raw_q  <= w_raw;
                wave_q <= w_wave;
            end
        end

        assign w_ch_rd[c]            = w_rd;
        assign wave_o[c*c_W +: c_W]  = wave_q;
    end

endmodule

`default_nettype wire
